// File: rtl/vga_canvas_reader.sv
// VGA scan-out for the paint canvas: 640x480@60 timing, 4x upscale of a sync-read
// framebuffer, cursor overlay latched once per frame so the cursor never tears.
module vga_canvas_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int SCALE  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] cursor_pixel,
  input  logic [11:0] cursor_colour,
  output logic [14:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int SCALE_SH = $clog2(SCALE);

  typedef struct packed {
    logic [14:0] idx;
    logic        vis;
    logic        hs;
    logic        vs;
    logic        fs;
  } side_t;

  localparam side_t SIDE_RST = '{idx: 15'd0, vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  x0;
  logic [9:0]  y0;
  side_t       s0;
  side_t       s1;
  side_t       dly [RD_LAT];
  side_t       s2;
  logic [11:0] pixel;
  logic [11:0] rgb;
  logic [14:0] cur_idx;
  logic [11:0] cur_col;
  logic        frame_end;

  assign frame_end = (h_cnt == 10'(H_TOTAL - 1)) && (v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 0: decode the counter position into canvas index and sync levels
  always_comb begin
    x0     = h_cnt >> SCALE_SH;
    y0     = v_cnt >> SCALE_SH;
    s0.idx = 15'(y0) * 15'(WIDTH) + 15'(x0);
    s0.vis = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    s0.hs  = !((h_cnt >= 10'(H_VIS + H_FP)) && (h_cnt < 10'(H_VIS + H_FP + H_SYNC)));
    s0.vs  = !((v_cnt >= 10'(V_VIS + V_FP)) && (v_cnt < 10'(V_VIS + V_FP + V_SYNC)));
    s0.fs  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Cursor is captured only on the last clock of the frame; idx never reaches 0x7FFF
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_idx <= 15'h7FFF;
      cur_col <= '0;
    end else if (frame_end) begin
      cur_idx <= cursor_pixel;
      cur_col <= cursor_colour;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      s1      <= SIDE_RST;
    end else begin
      rd_addr <= s0.vis ? s0.idx : 15'd0;
      s1      <= s0;
    end
  end

  // Sideband waits out the RAM read latency so it lines up with rd_data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= SIDE_RST;
    end else begin
      dly[0] <= s1;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  always_comb begin
    s2    = dly[RD_LAT-1];
    pixel = (s2.vis && (s2.idx == cur_idx)) ? cur_col : rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb         <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb         <= s2.vis ? pixel : 12'd0;
      vga_hsync   <= s2.hs;
      vga_vsync   <= s2.vs;
      frame_start <= s2.fs;
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule
